// File: rtl/mux_lut_pkg.sv
// Shared state type, default sizing and the select-remap helper for mux_lut_seq.
package mux_lut_pkg;

  localparam int SEL_W_DEF  = 3;
  localparam int NUM_CH_DEF = 2;
  localparam int TBL_W      = 2 ** SEL_W_DEF;
  localparam int CH_W       = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Maps an external select word onto the internal table index (bit order reversed when rev).
  function automatic logic [31:0] sel_remap(input logic [31:0] sel, input int w, input bit rev);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        if (rev) r[w-1-i] = sel[i];
        else     r[i]     = sel[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_tree_n.sv
// TBL_W:1 binary mux2 tree, split at level SEL_W/2 so the top can optionally register the mid tap.
module mux2 (
  input  logic a_i,
  input  logic b_i,
  input  logic s_i,
  output logic y_o
);
  assign y_o = s_i ? b_i : a_i;
endmodule

module mux_tree_n #(
  parameter  int SEL_W = 3,
  localparam int TW    = 2 ** SEL_W,
  localparam int LO    = SEL_W / 2,
  localparam int HI    = SEL_W - LO,
  localparam int MW    = 2 ** HI
) (
  input  logic [TW-1:0] data_i,
  input  logic [LO-1:0] sel_lo_i,
  output logic [MW-1:0] tap_o,
  input  logic [MW-1:0] mid_i,
  input  logic [HI-1:0] sel_hi_i,
  output logic          y_o
);

  for (genvar j = 0; j < LO; j++) begin : g_lo
    logic [(TW>>j)-1:0]     src;
    logic [(TW>>(j+1))-1:0] nd;
    if (j == 0) begin : g_in
      assign src = data_i;
    end else begin : g_in
      assign src = g_lo[j-1].nd;
    end
    for (genvar k = 0; k < (TW >> (j+1)); k++) begin : g_cell
      mux2 u_mux2 (.a_i(src[2*k]), .b_i(src[2*k+1]), .s_i(sel_lo_i[j]), .y_o(nd[k]));
    end
  end

  assign tap_o = g_lo[LO-1].nd;

  // Upper levels start from mid_i, which is either tap_o directly or its registered copy.
  for (genvar j = 0; j < HI; j++) begin : g_hi
    logic [(MW>>j)-1:0]     src;
    logic [(MW>>(j+1))-1:0] nd;
    if (j == 0) begin : g_in
      assign src = mid_i;
    end else begin : g_in
      assign src = g_hi[j-1].nd;
    end
    for (genvar k = 0; k < (MW >> (j+1)); k++) begin : g_cell
      mux2 u_mux2 (.a_i(src[2*k]), .b_i(src[2*k+1]), .s_i(sel_hi_i[j]), .y_o(nd[k]));
    end
  end

  assign y_o = g_hi[HI-1].nd[0];

endmodule

// File: rtl/mux_lut_seq.sv
// Multi-channel loadable truth-table engine with registered eval and full-table scan sequencer.
// Define MUX_LUT_PIPE_EN to register the mux tree mid tap (eval/scan latency 2 instead of 1).
module mux_lut_seq
  import mux_lut_pkg::*;
#(
  parameter  int              SEL_W       = SEL_W_DEF,
  parameter  int              NUM_CH      = NUM_CH_DEF,
  parameter  int              SEL_REV     = 0,
  parameter  logic [2**SEL_W-1:0] RESET_TABLE = '0,
  localparam int              TW          = 2 ** SEL_W,
  localparam int              CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [TW-1:0]    cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_ch,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_done,
  output logic             out_valid,
  output logic             out_y,
  output logic [CW-1:0]    out_ch,
  output logic [SEL_W-1:0] out_idx
);

  localparam int LO = SEL_W / 2;
  localparam int HI = SEL_W - LO;
  localparam int MW = 2 ** HI;
  localparam logic [SEL_W-1:0] LAST_IDX = '1;

  // state | meaning
  // IDLE  | cfg/eval accepted, scan_start sampled
  // SCAN  | emitting table[sch][idx] each cycle, cfg/eval blocked
  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CW-1:0]    sch_q, sch_d;
  logic [TW-1:0]    tbl_q [NUM_CH];

  logic             busy, cfg_acc, ev_acc, issue, issue_done;
  logic [CW-1:0]    mux_ch;
  logic [SEL_W-1:0] mux_idx, ev_idx;
  logic [TW-1:0]    mux_tbl;
  logic [MW-1:0]    tap, mid;
  logic [HI-1:0]    sel_hi;
  logic             y;

  logic             out_valid_q, out_y_q, done_q;
  logic [CW-1:0]    out_ch_q;
  logic [SEL_W-1:0] out_idx_q;

  assign busy      = (state_q == SCAN);
  assign cfg_ready = ~busy;
  assign in_ready  = ~busy;
  assign scan_busy = busy;
  assign cfg_acc   = cfg_valid & ~busy;
  assign ev_acc    = in_valid & ~busy;
  assign ev_idx    = SEL_W'(sel_remap(32'(in_sel), SEL_W, SEL_REV != 0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sch_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sch_q   <= sch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sch_d   = sch_q;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = SCAN;
          idx_d   = '0;
          sch_d   = in_ch;
        end
      end
      SCAN: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Eval wins the shared tree; it can only be accepted outside SCAN anyway.
  always_comb begin
    mux_ch  = sch_q;
    mux_idx = idx_q;
    if (ev_acc) begin
      mux_ch  = in_ch;
      mux_idx = ev_idx;
    end
  end

  // Unmatched (out-of-range) channels read as an all-zero table.
  always_comb begin
    mux_tbl = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mux_ch == CW'(c)) mux_tbl = tbl_q[c];
    end
  end

  assign issue      = ev_acc | busy;
  assign issue_done = busy & (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) tbl_q[c] <= RESET_TABLE;
    end else if (cfg_acc) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_ch == CW'(c)) tbl_q[c] <= cfg_data;
      end
    end
  end

  mux_tree_n #(.SEL_W(SEL_W)) u_tree (
    .data_i   (mux_tbl),
    .sel_lo_i (mux_idx[LO-1:0]),
    .tap_o    (tap),
    .mid_i    (mid),
    .sel_hi_i (sel_hi),
    .y_o      (y)
  );

`ifdef MUX_LUT_PIPE_EN
  logic             p_valid_q, p_done_q;
  logic [CW-1:0]    p_ch_q;
  logic [SEL_W-1:0] p_idx_q;
  logic [MW-1:0]    p_mid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid_q <= 1'b0;
      p_done_q  <= 1'b0;
      p_ch_q    <= '0;
      p_idx_q   <= '0;
      p_mid_q   <= '0;
    end else begin
      p_valid_q <= issue;
      p_done_q  <= issue_done;
      p_ch_q    <= mux_ch;
      p_idx_q   <= mux_idx;
      p_mid_q   <= tap;
    end
  end

  assign mid    = p_mid_q;
  assign sel_hi = p_idx_q[SEL_W-1:LO];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      out_ch_q    <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= p_valid_q;
      out_y_q     <= y;
      out_ch_q    <= p_ch_q;
      out_idx_q   <= p_idx_q;
      done_q      <= p_done_q;
    end
  end
`else
  assign mid    = tap;
  assign sel_hi = mux_idx[SEL_W-1:LO];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      out_ch_q    <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= issue;
      out_y_q     <= y;
      out_ch_q    <= mux_ch;
      out_idx_q   <= mux_idx;
      done_q      <= issue_done;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_ch    = out_ch_q;
  assign out_idx   = out_idx_q;
  assign scan_done = done_q;

endmodule
